// File: rtl/sig_a_pkg.sv
// Shared types and defaults for the transmit end of the 3-bit sig_a link.
package sig_a_pkg;

    typedef logic [2:0] sym_t;

    localparam sym_t IDLE_CODE_DEFAULT = 3'b101;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

endpackage

// File: rtl/sig_a_if.sv
// Valid/ready symbol link between sig_a_tx (master) and child (slave).
interface sig_a_if;
    import sig_a_pkg::*;

    sym_t sig_a;
    logic sig_a_valid;
    logic sig_a_ready;

    modport master (
        output sig_a,
        output sig_a_valid,
        input  sig_a_ready
    );

    modport slave (
        input  sig_a,
        input  sig_a_valid,
        output sig_a_ready
    );

endinterface

// File: rtl/sig_a_fifo.sv
// Small power-of-two symbol FIFO; occupancy is tracked explicitly so full/empty never alias.
module sig_a_fifo
    import sig_a_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  sym_t                     wr_data,
    output sym_t                     head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    sym_t           mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Storage needs no reset: the head is only shown to child while level is nonzero.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == (PW+1)'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/sig_a_tx.sv
// Transmit end of sig_a: buffers producer symbols and hands them to child, driving the
// idle code when nothing is pending and flagging a child that stalls too long.
module sig_a_tx
    import sig_a_pkg::*;
#(
    parameter int   DEPTH     = 4,
    parameter sym_t IDLE_CODE = IDLE_CODE_DEFAULT,
    parameter int   TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  sym_t                     in_data,
    input  logic                     flush,
    sig_a_if.master                  tx,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     stall_err
);

    localparam int         LW        = $clog2(DEPTH) + 1;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    tx_state_t  state;
    tx_state_t  state_next;
    logic [7:0] stall_cnt;
    logic [7:0] cnt_next;
    logic       err_next;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    sym_t       head;

    // in_ready depends only on registered occupancy, never on sig_a_ready.
    assign in_ready = !full;
    assign push     = in_valid & in_ready;
    assign pop      = tx.sig_a_valid & tx.sig_a_ready;

    sig_a_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (in_data),
        .head    (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            state     <= state_next;
            stall_cnt <= cnt_next;
            stall_err <= err_next;
        end
    end

    // The IDLE->SEND hop waits on registered level, giving one cycle from push to valid.
    always_comb begin
        state_next = state;
        cnt_next   = stall_cnt;
        err_next   = stall_err;
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
            err_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = '0;
                    if (!empty) begin
                        state_next = SEND;
                    end
                end
                SEND: begin
                    if (pop) begin
                        cnt_next = '0;
                        if (level == LW'(1) && !push) begin
                            state_next = IDLE;
                        end
                    end else begin
                        if (stall_cnt < TIMEOUT_C) begin
                            cnt_next = stall_cnt + 8'd1;
                        end
                        if (cnt_next == TIMEOUT_C) begin
                            err_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign tx.sig_a_valid = (state == SEND);
    assign tx.sig_a       = (state == SEND) ? head : IDLE_CODE;

endmodule

// File: doc/sig_a_tx.md
Name: sig_a_tx

Overview:
- Transmit end of the 3-bit sig_a interface consumed by child.
- Buffers 3-bit symbols from local producer logic in a small FIFO and presents them to child with a valid/ready handshake.
- Drives the idle code whenever nothing is pending.
- Instantiated inside top next to child. Its sig_a output connects to child's sig_a through the AUTO_TEMPLATE, so sig_a stays a local net and never appears in top's AUTOPORTS.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- IDLE_CODE, 3'b101, value driven on sig_a while sig_a_valid=0.
- TIMEOUT, 15, consecutive stalled cycles before stall_err sets; range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer symbol valid
- in_ready  out  1  FIFO can accept a symbol
- in_data  in  3  producer symbol
- flush  in  1  synchronous clear of FIFO, FSM and error
- sig_a  out  3  symbol to child
- sig_a_valid  out  1  sig_a carries a real symbol
- sig_a_ready  in  1  child accepts symbol
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- stall_err  out  1  sticky; child stalled for TIMEOUT cycles

Behaviour:
- Reset values (while rst_n=0): sig_a=IDLE_CODE, sig_a_valid=0, level=0, stall_err=0, stall counter=0, state IDLE, pointers 0. in_ready=1, since it is !full of reset registers.
- Push = in_valid & in_ready. Pop = sig_a_valid & sig_a_ready.
- in_ready = !full, taken from registered state only. There is no combinational path from sig_a_ready to in_ready. When full, a same-cycle pop does not enable a push.
- FSM, two states:
  - IDLE: sig_a_valid=0, sig_a=IDLE_CODE.
  - SEND: sig_a_valid=1, sig_a=FIFO head.
  - IDLE->SEND on the clock edge after level becomes nonzero.
  - SEND->IDLE when a pop empties the FIFO and there is no simultaneous push.
  - Pop and push in the same cycle with level=1 stays in SEND with the new head.
- Latency: a symbol pushed into an empty FIFO at edge N appears on sig_a with valid asserted from edge N+1.
- Handshake rules: once sig_a_valid is high, sig_a and sig_a_valid hold stable until a pop. No retraction, no reordering.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from level (0 means empty, DEPTH means full). level updates +1 on push only, -1 on pop only, unchanged on both.
- Stall counter, 8 bits:
  - Increments each cycle in SEND with sig_a_ready=0.
  - Clears on pop or in IDLE.
  - Saturates at TIMEOUT; reaching TIMEOUT sets stall_err.
  - stall_err stays set until flush or reset. Data continues to be held; no drop.
- flush:
  - Has priority over push and pop in the same cycle; neither takes effect.
  - Next cycle: level=0, state IDLE, sig_a=IDLE_CODE, stall_err=0, counter=0.
  - in_ready stays as !full during the flush cycle, but the push is ignored.
- Reset mid-transfer: all state is lost immediately on the asynchronous assert. Outputs return to reset values with no clock. Operation resumes on the first edge after rst_n deasserts.

Decomposition:
- Package sig_a_pkg holds:
  - typedef sym_t (logic [2:0]).
  - localparam IDLE_CODE_DEFAULT = 3'b101.
  - enum tx_state_t {IDLE, SEND}.
- Sub-module sig_a_fifo: DEPTH-entry sym_t storage, pointers and level, with push/pop/flush inputs. It is instantiated once via AUTOINST.
- FSM, stall counter and output muxing live in sig_a_tx.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, no input -> sig_a=3'b101, sig_a_valid=0, in_ready=1, level=0 throughout.
- Single symbol: push 3'b011 at edge N with sig_a_ready=1 -> sig_a=3'b011 and valid=1 at N+1; popped at N+1; back to 3'b101 and valid=0 at N+2.
- Fill and backpressure: sig_a_ready=0, push 1,2,3,4,5 -> in_ready drops after the 4th push, level=4, 5th not accepted. Then ready=1 -> sig_a emits 1,2,3,4 on consecutive cycles.
- Simultaneous push/pop at level=1: streaming pushes with ready=1 -> level stays 1, no bubble on sig_a_valid, order preserved.
- Stall timeout: one symbol pending, sig_a_ready=0 for 15 cycles -> stall_err=1 at the 15th, sig_a held stable. ready=1 pops it, stall_err stays 1. Flush -> stall_err=0.
- Flush and async reset: level=3, assert flush together with in_valid -> next cycle level=0, IDLE_CODE driven. Reasserting rst_n mid-SEND -> sig_a_valid=0 immediately without a clock edge.
